// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM memory port arbiter.
// Requester ids double as the registered winner encoding.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the view of the CPU plus memory macro.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select for the shared port: DM first, but IF is forced through
// after STARVE_MAX consecutive contested DM wins.
module arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic take,
  output logic winner
);
  import mem_port_arbiter_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q;
  logic          contested;
  logic          force_if;

  assign contested = if_req & dm_req;
  assign force_if  = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    winner = REQ_IF;
    if (dm_req && !(contested && force_if)) begin
      winner = REQ_DM;
    end
  end

  // Only contested DM wins count; an uncontested DM grant leaves the count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (take) begin
      if (winner == REQ_IF) begin
        starve_q <= '0;
      end else if (contested) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (DM)
// paths, one transaction in flight at a time.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate pending requests
// ISSUE | mem_en strobe and grant pulse to the registered winner
// WAIT  | latency down-counter running (absent when MEM_LAT=1)
// RESP  | read data returned, valid pulse, arbitrate for the next access
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  import mem_port_arbiter_pkg::*;

  localparam int               LAT_W    = $clog2(MEM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [LAT_W-1:0]  lat_q;
  logic              lat_tc;

  logic              any_req;
  logic              arb_pt;
  logic              take;
  logic              winner;

  logic              winner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              in_issue;
  logic              in_resp;
  logic              resp_if;
  logic              resp_dm;

  assign any_req = bus.if_req | bus.dm_req;
  assign arb_pt  = (state_q == IDLE) || (state_q == RESP);
  assign take    = arb_pt & any_req;
  assign lat_tc  = (lat_q == LAT_W'(1));

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .take   (take),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        if (MEM_LAT == 1) state_d = RESP;
        else              state_d = WAIT;
      end
      WAIT: begin
        if (lat_tc) state_d = RESP;
      end
      RESP: begin
        if (any_req) state_d = ISSUE;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loaded with the number of WAIT cycles; RESP follows the cycle the count reaches 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_q <= '0;
    end else if (state_q == ISSUE) begin
      lat_q <= LAT_INIT;
    end else if (state_q == WAIT) begin
      lat_q <= lat_q - LAT_W'(1);
    end
  end

  // Request fields are latched at the arbitration point and held until the
  // next one, which is what keeps mem_addr/mem_wdata/mem_we stable outside ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_q <= REQ_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (take) begin
      winner_q <= winner;
      if (winner == REQ_DM) begin
        we_q    <= bus.dm_we;
        addr_q  <= bus.dm_addr;
        wdata_q <= bus.dm_wdata;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= bus.if_addr;
      end
    end
  end

  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);
  assign resp_if  = in_resp && (winner_q == REQ_IF);
  assign resp_dm  = in_resp && (winner_q == REQ_DM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (resp_if)          if_rdata_q <= bus.mem_rdata;
      if (resp_dm && !we_q) dm_rdata_q <= bus.mem_rdata;
    end
  end

  // Memory data is only valid during RESP, so it is forwarded in that cycle
  // alongside the valid pulse and held from the register afterwards.
  assign bus.if_rdata  = resp_if ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata  = (resp_dm && !we_q) ? bus.mem_rdata : dm_rdata_q;

  assign bus.if_gnt    = in_issue && (winner_q == REQ_IF);
  assign bus.dm_gnt    = in_issue && (winner_q == REQ_DM);
  assign bus.if_valid  = resp_if;
  assign bus.dm_valid  = resp_dm;

  assign bus.mem_en    = in_issue;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances with MEM_LAT 1..4 share stimulus,
// one is active at a time while the others sit in reset.
module tb_mem_port_arbiter;

  localparam int NDUT = 4;
  localparam int SMAX = 4;

  typedef struct packed {
    logic        busy;
    logic        if_gnt;
    logic        if_valid;
    logic        dm_gnt;
    logic        dm_valid;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_act;
  int          sel;
  int          lat;

  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] mem_rdata;

  outs_t       o [NDUT];
  logic        rst_v [NDUT];
  outs_t       d;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign rst_v[gi]     = rst_act && (sel == gi);
    assign bus.if_req    = if_req;
    assign bus.if_addr   = if_addr;
    assign bus.dm_req    = dm_req;
    assign bus.dm_we     = dm_we;
    assign bus.dm_addr   = dm_addr;
    assign bus.dm_wdata  = dm_wdata;
    assign bus.mem_rdata = mem_rdata;
    assign o[gi] = {bus.busy, bus.if_gnt, bus.if_valid, bus.dm_gnt, bus.dm_valid,
                    bus.mem_en, bus.mem_we, bus.if_rdata, bus.dm_rdata,
                    bus.mem_addr, bus.mem_wdata};

    mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MEM_LAT    (gi + 1),
      .STARVE_MAX (SMAX)
    ) u_dut (
      .clk (clk),
      .rst (rst_v[gi]),
      .bus (bus)
    );
  end

  int errors = 0;
  int checks = 0;
  int cnum   = 0;

  // memory macro emulation (driven by what the DUT actually issues)
  logic [31:0] env_mem [64];
  int          rd_due;
  logic [31:0] rd_val;

  // requester agents
  bit          if_pend, dm_pend, dm_w;
  logic [31:0] if_a, dm_a, dm_wd;

  // reference model: one transaction record plus the visible held values
  logic [31:0] mdl_mem [64];
  bit          m_act, m_dm, m_we;
  int          m_iss, m_rsp, m_sc;
  logic [31:0] m_addr, m_wd, m_rval;
  logic [31:0] h_addr, h_wd, e_if_rd, e_dm_rd;
  bit          h_we;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %b expected %b", nm, cnum, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cnum, act, exp);
    end
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 1) r[7:4] = 4'h0;
    return r;
  endfunction

  task automatic model_reset();
    m_act   = 1'b0;
    m_sc    = 0;
    h_addr  = '0;
    h_wd    = '0;
    h_we    = 1'b0;
    e_if_rd = '0;
    e_dm_rd = '0;
    rd_due  = -1;
    if_pend = 1'b0;
    dm_pend = 1'b0;
  endtask

  task automatic compare();
    bit iss, rsp, bsy;
    iss = m_act && (cnum == m_iss);
    rsp = m_act && (cnum == m_rsp);
    bsy = m_act && (cnum >= m_iss) && (cnum <= m_rsp);
    if (iss) begin
      h_addr = m_addr;
      if (m_dm) begin
        h_wd = m_wd;
        h_we = m_we;
      end else begin
        h_we = 1'b0;
      end
    end
    if (rsp) begin
      if (!m_dm)     e_if_rd = m_rval;
      else if (!m_we) e_dm_rd = m_rval;
    end
    chk1 ("busy",      d.busy,      bsy);
    chk1 ("mem_en",    d.mem_en,    iss);
    chk1 ("if_gnt",    d.if_gnt,    iss && !m_dm);
    chk1 ("dm_gnt",    d.dm_gnt,    iss && m_dm);
    chk1 ("if_valid",  d.if_valid,  rsp && !m_dm);
    chk1 ("dm_valid",  d.dm_valid,  rsp && m_dm);
    chk1 ("mem_we",    d.mem_we,    h_we);
    chk32("mem_addr",  d.mem_addr,  h_addr);
    chk32("mem_wdata", d.mem_wdata, h_wd);
    chk32("if_rdata",  d.if_rdata,  e_if_rd);
    chk32("dm_rdata",  d.dm_rdata,  e_dm_rd);
  endtask

  // Arbitration is possible whenever no transaction occupies ISSUE..WAIT.
  task automatic model_arb();
    bit dm_win;
    if (!rst_act) return;
    if (m_act && (cnum >= m_iss) && (cnum < m_rsp)) return;
    if (!if_req && !dm_req) return;
    if (if_req && dm_req) begin
      if (m_sc >= SMAX) dm_win = 1'b0;
      else begin
        dm_win = 1'b1;
        m_sc++;
      end
    end else begin
      dm_win = dm_req;
    end
    if (!dm_win) m_sc = 0;
    m_act = 1'b1;
    m_dm  = dm_win;
    m_iss = cnum + 1;
    m_rsp = cnum + 1 + lat;
    if (dm_win) begin
      m_addr = dm_addr;
      m_wd   = dm_wdata;
      m_we   = dm_we;
    end else begin
      m_addr = if_addr;
      m_we   = 1'b0;
    end
    m_rval = mdl_mem[m_addr[7:2]];
    if (m_dm && m_we) mdl_mem[m_addr[7:2]] = m_wd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cnum++;
    d = o[sel];
    if (d.mem_en) begin
      rd_val = env_mem[d.mem_addr[7:2]];
      if (d.mem_we) env_mem[d.mem_addr[7:2]] = d.mem_wdata;
      rd_due = cnum + lat;
    end
    mem_rdata = (cnum == rd_due) ? rd_val : $urandom;
    if_req   = if_pend;
    if_addr  = if_a;
    dm_req   = dm_pend;
    dm_we    = dm_w;
    dm_addr  = dm_a;
    dm_wdata = dm_wd;
    if (d.if_gnt) if_pend = 1'b0;
    if (d.dm_gnt) dm_pend = 1'b0;
    #1;
    d = o[sel];
    compare();
    model_arb();
  endtask

  task automatic sel_dut(input int k);
    rst_act = 1'b0;
    sel     = k;
    lat     = k + 1;
    model_reset();
    cyc();
    chk1 ("rst_busy",     d.busy,     1'b0);
    chk1 ("rst_mem_en",   d.mem_en,   1'b0);
    chk32("rst_mem_addr", d.mem_addr, 32'h0);
    chk32("rst_if_rdata", d.if_rdata, 32'h0);
    rst_act = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!if_pend && !dm_pend && !d.busy) break;
      cyc();
    end
    chk1("drain_idle", d.busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, vc, bcnt, n, vcount;
    bit order [12];
    bit exp_order [12];
    int exp_lat [4];
    logic [31:0] v;

    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    exp_lat   = '{2, 3, 4, 5};

    rst_act = 1'b0; sel = 0; lat = 1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    if_a = 0; dm_a = 0; dm_wd = 0; dm_w = 0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      env_mem[i] = v;
      mdl_mem[i] = v;
    end
    model_reset();

    // single fetch, MEM_LAT=1
    sel_dut(0);
    env_mem[4] = 32'h0050_0093;
    mdl_mem[4] = 32'h0050_0093;
    if_a = 32'h10; if_pend = 1'b1;
    cyc();
    cyc();
    chk1 ("fetch_gnt",  d.if_gnt,   1'b1);
    chk32("fetch_addr", d.mem_addr, 32'h10);
    chk1 ("fetch_we",   d.mem_we,   1'b0);
    cyc();
    chk1 ("fetch_valid", d.if_valid, 1'b1);
    chk32("fetch_rdata", d.if_rdata, 32'h0050_0093);
    drain();

    // store then load, MEM_LAT=2
    sel_dut(1);
    dm_a = 32'h20; dm_wd = 32'hDEAD_BEEF; dm_w = 1'b1; dm_pend = 1'b1;
    cyc();
    cyc();
    chk1 ("st_gnt",   d.dm_gnt,    1'b1);
    chk1 ("st_we",    d.mem_we,    1'b1);
    chk32("st_wdata", d.mem_wdata, 32'hDEAD_BEEF);
    cyc();
    cyc();
    chk1 ("st_ack",   d.dm_valid,  1'b1);
    chk32("st_rdata", d.dm_rdata,  32'h0);
    dm_w = 1'b0; dm_pend = 1'b1;
    cyc();
    cyc();
    chk1 ("ld_we", d.mem_we, 1'b0);
    cyc();
    cyc();
    chk1 ("ld_valid", d.dm_valid, 1'b1);
    chk32("ld_rdata", d.dm_rdata, 32'hDEAD_BEEF);
    drain();

    // back-to-back: DM request raised in the RESP cycle of an IF access
    if_a = raddr(); if_pend = 1'b1;
    cyc();
    cyc();
    cyc();
    dm_a = 32'h20; dm_w = 1'b0; dm_pend = 1'b1;
    cyc();
    chk1("b2b_resp_valid", d.if_valid, 1'b1);
    chk1("b2b_resp_busy",  d.busy,     1'b1);
    cyc();
    chk1("b2b_issue_gnt",  d.dm_gnt,   1'b1);
    chk1("b2b_issue_busy", d.busy,     1'b1);
    drain();

    // contention, both held high, MEM_LAT=1
    sel_dut(0);
    n = 0;
    for (int i = 0; i < 200 && n < 12; i++) begin
      if (!if_pend) begin if_pend = 1'b1; if_a = raddr(); end
      if (!dm_pend) begin dm_pend = 1'b1; dm_a = raddr(); dm_wd = $urandom; dm_w = $urandom_range(0, 1); end
      cyc();
      if (d.if_gnt || d.dm_gnt) begin
        order[n] = d.dm_gnt;
        n++;
      end
    end
    chk32("contend_count", n, 12);
    for (int i = 0; i < 12; i++) chk1($sformatf("contend_order%0d", i), order[i], exp_order[i]);
    drain();

    // latency sweep
    for (int k = 0; k < NDUT; k++) begin
      sel_dut(k);
      if_a = raddr(); if_pend = 1'b1;
      cyc();
      t = cnum; vc = -1; bcnt = 0;
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (d.busy) bcnt++;
        if (d.if_valid) begin
          vc = cnum;
          break;
        end
      end
      chk32($sformatf("lat_valid_L%0d", k + 1), vc - t, exp_lat[k]);
      chk32($sformatf("lat_busy_L%0d", k + 1),  bcnt,   exp_lat[k]);
      drain();
    end

    // reset in the middle of WAIT, MEM_LAT=3
    sel_dut(2);
    dm_a = 32'h20; dm_w = 1'b0; dm_pend = 1'b1;
    cyc();
    cyc();
    chk1("rstw_gnt", d.dm_gnt, 1'b1);
    cyc();
    chk1("rstw_in_wait", d.busy && !d.mem_en, 1'b1);
    rst_act = 1'b0;
    model_reset();
    #1;
    d = o[sel];
    chk1 ("rstw_busy",     d.busy,     1'b0);
    chk1 ("rstw_dm_valid", d.dm_valid, 1'b0);
    chk32("rstw_mem_addr", d.mem_addr, 32'h0);
    chk32("rstw_dm_rdata", d.dm_rdata, 32'h0);
    cyc();
    cyc();
    rst_act = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (d.if_valid || d.dm_valid) vcount++;
    end
    chk32("rstw_stale_valid", vcount, 0);

    // randomized traffic on every latency
    for (int k = 0; k < NDUT; k++) begin
      sel_dut(k);
      for (int i = 0; i < 500; i++) begin
        if (!if_pend && $urandom_range(0, 2) == 0) begin
          if_pend = 1'b1;
          if_a    = raddr();
        end
        if (!dm_pend && $urandom_range(0, 2) == 0) begin
          dm_pend = 1'b1;
          dm_w    = $urandom_range(0, 1);
          dm_a    = raddr();
          dm_wd   = $urandom;
        end
        cyc();
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
